// File: rtl/inst_loader.sv
// inst_loader
//   Write side of the instruction memory. Takes a program image as a byte
//   stream and writes 32-bit words into the instruction RAM. The CPU is held
//   in reset (cpu_hold) until a complete image has been loaded.
//   Frame layout: 16-bit word count N (big-endian), then N words of 4 bytes
//   each, MSB first.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-low reset
//   rx_data    in   received byte, valid when rx_valid=1
//   rx_valid   in   one-cycle strobe per byte; every strobe is consumed
//   mem_we     out  RAM write enable, one-cycle pulse per word
//   mem_addr   out  word-aligned byte address of the write
//   mem_wdata  out  instruction word to write
//   cpu_hold   out  1 = keep CPU in reset; 0 = program loaded
//   load_done  out  one-cycle pulse when a frame completes successfully
//   load_err   out  sticky error; cleared by reset or the next frame start
module inst_loader #(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  // One extra bit so word_idx can reach DEPTH without wrapping.
  localparam int IDX_W = $clog2(DEPTH) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  // Only the three older bytes need storing; the fourth comes straight
  // from rx_data when the word is written.
  logic [23:0]       shift_q, shift_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic [15:0]       len_rx;
  logic [15:0]       words_after;
  logic              timeout_hit;

  // Full length as it stands when the low count byte arrives.
  assign len_rx      = {count_q[15:8], rx_data};
  // Number of words written once the word in progress completes.
  assign words_after = 16'(word_idx_q) + 16'd1;
  // The current idle cycle is the TIMEOUT_CYCLES-th one.
  assign timeout_hit = (timeout_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    timeout_d   = timeout_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = 1'b1;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;

    case (state_q)
      S_LEN_HI: begin
        timeout_d = '0;
        if (rx_valid) begin
          count_d[15:8] = rx_data;
          load_err_d    = 1'b0;
          state_d       = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (rx_valid) begin
          timeout_d    = '0;
          count_d[7:0] = rx_data;
          if (len_rx == 16'd0) begin
            load_done_d = 1'b1;
            state_d     = S_RUN;
          end else if (32'(len_rx) > DEPTH) begin
            load_err_d = 1'b1;
            state_d    = S_LEN_HI;
          end else begin
            word_idx_d = '0;
            byte_idx_d = 2'd0;
            state_d    = S_DATA;
          end
        end else if (timeout_hit) begin
          load_err_d = 1'b1;
          timeout_d  = '0;
          state_d    = S_LEN_HI;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          timeout_d  = '0;
          shift_d    = {shift_q[15:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {shift_q, rx_data};
            mem_addr_d  = 32'({word_idx_q, 2'b00});
            word_idx_d  = word_idx_q + IDX_W'(1);
            // Last word: done pulses alongside its write; the CPU is
            // released on the following cycle from S_RUN.
            if (words_after == count_q) begin
              load_done_d = 1'b1;
              state_d     = S_RUN;
            end
          end
        end else if (timeout_hit) begin
          // Partial word is dropped; words already written stay in RAM.
          load_err_d = 1'b1;
          timeout_d  = '0;
          state_d    = S_LEN_HI;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end

      S_RUN: begin
        timeout_d  = '0;
        // Any byte here is the high count byte of a new frame.
        cpu_hold_d = rx_valid;
        if (rx_valid) begin
          count_d[15:8] = rx_data;
          load_err_d    = 1'b0;
          state_d       = S_LEN_LO;
        end
      end

      default: state_d = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_LEN_HI;
      count_q     <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      timeout_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      timeout_q   <= timeout_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader
//   Drives byte-stream frames into inst_loader and compares the observed RAM
//   writes and status outputs against a frame-level model of the loader.
module tb_inst_loader;

  localparam int DEPTH   = 256;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Observed activity, appended only by the monitor below.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_total = 0;

  // Frame under construction for run_frame.
  logic [7:0]  frame_q[$];

  inst_loader #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (load_done) done_total++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Count header plus 4*n random payload bytes (payload only when n is legal).
  task automatic build_frame(input int n);
    frame_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    if (n <= DEPTH)
      for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
  endtask

  // Model: a legal N yields N writes at 4*i with MSB-first words, one done
  // pulse and a released CPU; N > DEPTH yields no write, load_err and hold.
  task automatic run_frame(input int gap_max);
    int          n, wbase, dbase, exp_writes, exp_done;
    logic        exp_err, exp_hold;
    logic [31:0] w;
    wbase = wr_addr_q.size();
    dbase = done_total;
    n = int'(frame_q[0]) * 256 + int'(frame_q[1]);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i]);
      idle($urandom_range(gap_max, 0));
    end
    idle(3);
    exp_writes = (n > DEPTH) ? 0 : n;
    exp_done   = (n > DEPTH) ? 0 : 1;
    exp_err    = (n > DEPTH);
    exp_hold   = (n > DEPTH);
    n_cmp++;
    if (wr_addr_q.size() - wbase !== exp_writes) begin
      n_fail++;
      $display("FAIL frame_writes n=%0d: got %0d required %0d", n, wr_addr_q.size() - wbase, exp_writes);
    end
    for (int i = 0; i < exp_writes && wbase + i < wr_addr_q.size(); i++) begin
      w = {frame_q[2+4*i], frame_q[3+4*i], frame_q[4+4*i], frame_q[5+4*i]};
      n_cmp++;
      if (wr_addr_q[wbase+i] !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL frame_addr[%0d]: got %h required %h", i, wr_addr_q[wbase+i], 32'(4 * i));
      end
      n_cmp++;
      if (wr_data_q[wbase+i] !== w) begin
        n_fail++;
        $display("FAIL frame_data[%0d]: got %h required %h", i, wr_data_q[wbase+i], w);
      end
    end
    n_cmp++;
    if (done_total - dbase !== exp_done) begin
      n_fail++;
      $display("FAIL frame_done n=%0d: got %0d required %0d", n, done_total - dbase, exp_done);
    end
    n_cmp++;
    if (load_err !== exp_err) begin
      n_fail++;
      $display("FAIL frame_err n=%0d: got %b required %b", n, load_err, exp_err);
    end
    n_cmp++;
    if (cpu_hold !== exp_hold) begin
      n_fail++;
      $display("FAIL frame_hold n=%0d: got %b required %b", n, cpu_hold, exp_hold);
    end
    $display("frame n=%0d gap_max=%0d writes=%0d done=%0d err=%b hold=%b",
             n, gap_max, wr_addr_q.size() - wbase, done_total - dbase, load_err, cpu_hold);
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++; if (mem_we !== 1'b0)     begin n_fail++; $display("FAIL %s mem_we: got %b required 0", tag, mem_we); end
    n_cmp++; if (mem_addr !== 32'd0)  begin n_fail++; $display("FAIL %s mem_addr: got %h required 0", tag, mem_addr); end
    n_cmp++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL %s mem_wdata: got %h required 0", tag, mem_wdata); end
    n_cmp++; if (cpu_hold !== 1'b1)   begin n_fail++; $display("FAIL %s cpu_hold: got %b required 1", tag, cpu_hold); end
    n_cmp++; if (load_done !== 1'b0)  begin n_fail++; $display("FAIL %s load_done: got %b required 0", tag, load_done); end
    n_cmp++; if (load_err !== 1'b0)   begin n_fail++; $display("FAIL %s load_err: got %b required 0", tag, load_err); end
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    check_reset_values("reset");
    $display("reset applied: hold=%b err=%b", cpu_hold, load_err);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] b[6];
    b = '{8'h00, 8'h01, 8'h20, 8'h10, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) send_byte(b[i]);
    // One cycle after the 4th data strobe: write and done together.
    n_cmp++; if (mem_we !== 1'b1)            begin n_fail++; $display("FAIL single_we: got %b required 1", mem_we); end
    n_cmp++; if (mem_addr !== 32'd0)         begin n_fail++; $display("FAIL single_addr: got %h required 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h20100000) begin n_fail++; $display("FAIL single_data: got %h required 20100000", mem_wdata); end
    n_cmp++; if (load_done !== 1'b1)         begin n_fail++; $display("FAIL single_done: got %b required 1", load_done); end
    n_cmp++; if (cpu_hold !== 1'b1)          begin n_fail++; $display("FAIL single_hold_pre: got %b required 1", cpu_hold); end
    tick();
    n_cmp++; if (cpu_hold !== 1'b0)          begin n_fail++; $display("FAIL single_hold_post: got %b required 0", cpu_hold); end
    n_cmp++; if (mem_we !== 1'b0)            begin n_fail++; $display("FAIL single_we_post: got %b required 0", mem_we); end
    n_cmp++; if (load_done !== 1'b0)         begin n_fail++; $display("FAIL single_done_post: got %b required 0", load_done); end
    n_cmp++; if (mem_wdata !== 32'h20100000) begin n_fail++; $display("FAIL single_data_hold: got %h required 20100000", mem_wdata); end
    $display("single word: addr=%h data=%h hold=%b", mem_addr, mem_wdata, cpu_hold);
  endtask

  task automatic push_word(input logic [31:0] w);
    frame_q.push_back(w[31:24]); frame_q.push_back(w[23:16]);
    frame_q.push_back(w[15:8]);  frame_q.push_back(w[7:0]);
  endtask

  task automatic test_back_to_back();
    frame_q.delete();
    frame_q.push_back(8'h00); frame_q.push_back(8'h03);
    push_word(32'h200a0004); push_word(32'h8e110000); push_word(32'h222cffff);
    run_frame(0);
  endtask

  task automatic test_too_long();
    build_frame(257);
    run_frame(1);
    build_frame(0);
    run_frame(1);
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 8; k++) begin
      n = (k == 5) ? 256 + $urandom_range(60, 1) : $urandom_range(8, 0);
      build_frame(n);
      run_frame(k % 3);
    end
  endtask

  task automatic test_full_depth();
    build_frame(DEPTH);
    run_frame(0);
  endtask

  task automatic test_timeout();
    int          wbase, dbase;
    logic [31:0] w;
    build_frame(2);
    wbase = wr_addr_q.size();
    dbase = done_total;
    for (int i = 0; i < 7; i++) send_byte(frame_q[i]);
    idle(TIMEOUT - 2);
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early_err: got %b required 0", load_err); end
    idle(4);
    w = {frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
    n_cmp++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b required 1", load_err); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL timeout_hold: got %b required 1", cpu_hold); end
    n_cmp++;
    if (wr_addr_q.size() - wbase !== 1) begin
      n_fail++; $display("FAIL timeout_writes: got %0d required 1", wr_addr_q.size() - wbase);
    end else begin
      n_cmp++; if (wr_addr_q[wbase] !== 32'd0) begin n_fail++; $display("FAIL timeout_addr: got %h required 0", wr_addr_q[wbase]); end
      n_cmp++; if (wr_data_q[wbase] !== w)     begin n_fail++; $display("FAIL timeout_data: got %h required %h", wr_data_q[wbase], w); end
    end
    n_cmp++; if (done_total - dbase !== 0) begin n_fail++; $display("FAIL timeout_done: got %0d required 0", done_total - dbase); end
    $display("timeout: err=%b hold=%b writes=%0d", load_err, cpu_hold, wr_addr_q.size() - wbase);
    // A fresh frame must be parsed from its count bytes.
    build_frame(1);
    run_frame(1);
  endtask

  task automatic test_reload();
    int          wbase;
    logic [31:0] w;
    w = $urandom;
    wbase = wr_addr_q.size();
    n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reload_pre_hold: got %b required 0", cpu_hold); end
    send_byte(8'h00);
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reload_hold: got %b required 1", cpu_hold); end
    send_byte(8'h01);
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    idle(3);
    n_cmp++;
    if (wr_addr_q.size() - wbase !== 1) begin
      n_fail++; $display("FAIL reload_writes: got %0d required 1", wr_addr_q.size() - wbase);
    end else begin
      n_cmp++; if (wr_addr_q[wbase] !== 32'd0) begin n_fail++; $display("FAIL reload_addr: got %h required 0", wr_addr_q[wbase]); end
      n_cmp++; if (wr_data_q[wbase] !== w)     begin n_fail++; $display("FAIL reload_data: got %h required %h", wr_data_q[wbase], w); end
    end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reload_release: got %b required 0", cpu_hold); end
    $display("reload: word=%h hold=%b", w, cpu_hold);
  endtask

  task automatic test_reset_midframe();
    int wbase;
    wbase = wr_addr_q.size();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hde); send_byte(8'had);
    reset = 1'b0;
    tick();
    check_reset_values("midreset");
    reset = 1'b1;
    idle(2);
    n_cmp++;
    if (wr_addr_q.size() - wbase !== 0) begin
      n_fail++; $display("FAIL midreset_writes: got %0d required 0", wr_addr_q.size() - wbase);
    end
    $display("mid-frame reset: hold=%b writes=%0d", cpu_hold, wr_addr_q.size() - wbase);
    build_frame(2);
    run_frame(1);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_too_long();
    test_reload();
    test_timeout();
    test_random();
    test_full_depth();
    test_reload();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
